audio_window_ctrl: RTL and testbench

Sequencer for the microphone volume-metering path. It derives the 20 kHz sample strobe from the system clock and runs fixed-length acquisition windows with peak capture. At each window end it quantizes the peak to a 0–9 volume level and publishes it over a valid/ready handshake to the display consumer (LED bar / 7-segment driver). It replaces free-running per-task sampling loops with one owner of the window, peak-clear and update timing.

---
 rtl/audio_pkg.sv | 18 +
 rtl/audio_level_quant.sv | 39 +++
 rtl/audio_window_ctrl.sv | 149 ++++++++++++++
 tb/tb_audio_window_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared widths, quantizer constants and sequencer state encoding
package audio_pkg;

  localparam int SAMPLE_W     = 12;
  localparam int LEVEL_W      = 4;
  localparam int LEVEL_MAX    = 9;
  localparam int LED_W        = 9;
  localparam int BASE_DEFAULT = 2048;
  // One volume step per 128 counts above the idle level.
  localparam int LEVEL_SHIFT  = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_QUANT   = 2'd2
  } state_e;

endpackage

// File: rtl/audio_level_quant.sv
// rtl/audio_level_quant.sv - combinational peak to volume level and thermometer bar
module audio_level_quant
  import audio_pkg::*;
#(
  parameter int BASE = BASE_DEFAULT
) (
  input  logic [SAMPLE_W-1:0] peak_i,
  output logic [LEVEL_W-1:0]  level_o,
  output logic [LED_W-1:0]    led_o
);

  logic [SAMPLE_W-1:0] diff;
  logic [SAMPLE_W-1:0] steps;

  // Subtract only above the idle level so the difference can never wrap.
  always_comb begin
    diff    = '0;
    steps   = '0;
    level_o = '0;
    if (peak_i > SAMPLE_W'(BASE)) begin
      diff  = peak_i - SAMPLE_W'(BASE);
      steps = diff >> LEVEL_SHIFT;
      if (steps > SAMPLE_W'(LEVEL_MAX)) begin
        level_o = LEVEL_W'(LEVEL_MAX);
      end else begin
        level_o = steps[LEVEL_W-1:0];
      end
    end
  end

  // Light the lowest 'level' segments of the bar.
  always_comb begin
    led_o = '0;
    for (int i = 0; i < LED_W; i++) begin
      led_o[i] = (i < int'(level_o));
    end
  end

endmodule

// File: rtl/audio_window_ctrl.sv
// rtl/audio_window_ctrl.sv - sample strobe, windowed peak capture and level publishing
module audio_window_ctrl
  import audio_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SAMPLE_HZ = 20_000,
  parameter int WINDOW    = 4000,
  parameter int BASE      = BASE_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] mic_in,
  output logic                sample_tick,
  output logic                level_valid,
  input  logic                level_ready,
  output logic [LEVEL_W-1:0]  level,
  output logic [SAMPLE_W-1:0] peak,
  output logic [LED_W-1:0]    led,
  output logic                overrun
);

  localparam int DIV    = CLK_HZ / SAMPLE_HZ;
  localparam int DIV_W  = $clog2(DIV);
  localparam int SAMP_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [SAMP_W-1:0]   samp_q, samp_d;
  logic [SAMPLE_W-1:0] acc_q, acc_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic                valid_q, valid_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [SAMPLE_W-1:0] peak_q, peak_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic                overrun_q, overrun_d;

  logic                running, tick, last_tick, load;
  logic [SAMPLE_W-1:0] sample_max;
  logic [LEVEL_W-1:0]  q_level;
  logic [LED_W-1:0]    q_led;

  assign running    = (state_q != ST_IDLE);
  assign tick       = running && (div_q == DIV_W'(DIV - 1));
  assign last_tick  = tick && (samp_q == SAMP_W'(WINDOW - 1));
  assign sample_max = (mic_in > acc_q) ? mic_in : acc_q;
  assign load       = enable && (state_q == ST_QUANT);

  audio_level_quant #(.BASE(BASE)) u_quant (
    .peak_i  (hold_q),
    .level_o (q_level),
    .led_o   (q_led)
  );

  // Sequencer state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: enable low forces idle ahead of every other transition.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_ACQUIRE;
        ST_ACQUIRE: if (last_tick) state_d = ST_QUANT;
        ST_QUANT:   state_d = ST_ACQUIRE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Divider, sample counter and peak tracking; hold latches the closing window's peak.
  always_comb begin
    div_d  = div_q;
    samp_d = samp_q;
    acc_d  = acc_q;
    hold_d = hold_q;
    if (!enable || !running) begin
      div_d  = '0;
      samp_d = '0;
      acc_d  = '0;
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (last_tick) begin
        hold_d = sample_max;
        acc_d  = '0;
        samp_d = '0;
      end else if (tick) begin
        acc_d  = sample_max;
        samp_d = samp_q + SAMP_W'(1);
      end
    end
  end

  // Published result and handshake; a load on a transfer edge keeps valid high.
  always_comb begin
    level_d   = level_q;
    peak_d    = peak_q;
    led_d     = led_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load) begin
      level_d = q_level;
      peak_d  = hold_q;
      led_d   = q_led;
      valid_d = 1'b1;
      if (valid_q && !level_ready) overrun_d = 1'b1;
    end else if (valid_q && level_ready) begin
      valid_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q     <= '0;
      samp_q    <= '0;
      acc_q     <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      level_q   <= '0;
      peak_q    <= '0;
      led_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      samp_q    <= samp_d;
      acc_q     <= acc_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      level_q   <= level_d;
      peak_q    <= peak_d;
      led_q     <= led_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_tick = tick;
  assign level_valid = valid_q;
  assign level       = level_q;
  assign peak        = peak_q;
  assign led         = led_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_audio_window_ctrl.sv
// tb/tb_audio_window_ctrl.sv - directed self-checking bench for audio_window_ctrl
module tb_audio_window_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] mic_in = 12'd0;
  logic        level_ready = 1'b0;
  logic        sample_tick;
  logic        level_valid;
  logic [3:0]  level;
  logic [11:0] peak;
  logic [8:0]  led;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  audio_window_ctrl #(
    .CLK_HZ    (100),
    .SAMPLE_HZ (10),
    .WINDOW    (4),
    .BASE      (2048)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .mic_in      (mic_in),
    .sample_tick (sample_tick),
    .level_valid (level_valid),
    .level_ready (level_ready),
    .level       (level),
    .peak        (peak),
    .led         (led),
    .overrun     (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (sample_tick !== 1'b1 && n < 40);
  endtask

  task automatic drive(input logic [11:0] v, input int exp_n);
    int n;
    wait_tick(n);
    chk("tick_spacing", n, exp_n);
    mic_in = v;
  endtask

  task automatic window4(input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] c, input logic [11:0] d, input int first_n);
    drive(a, first_n);
    drive(b, 10);
    drive(c, 10);
    drive(d, 10);
  endtask

  task automatic check_result(input string tag, input logic [11:0] ep,
                              input logic [3:0] el, input logic [8:0] ed);
    @(negedge clock);
    @(negedge clock);
    chk({tag, "_valid"}, level_valid, 1);
    chk({tag, "_peak"}, peak, ep);
    chk({tag, "_level"}, level, el);
    chk({tag, "_led"}, led, ed);
  endtask

  initial begin
    int n;
    // 1: reset values, then idle-level window with ready high
    enable = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_valid", level_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_peak", peak, 0);
    chk("rst_led", led, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_tick", sample_tick, 0);
    reset = 1'b0;
    level_ready = 1'b1;
    mic_in = 12'd2048;
    window4(2048, 2048, 2048, 2048, 10);
    check_result("idle", 2048, 0, 9'h000);
    @(negedge clock);
    chk("valid_one_cycle", level_valid, 0);

    // 2: mixed window, then accumulator cleared between windows
    window4(2100, 3000, 2500, 2200, 7);
    check_result("mixed", 3000, 7, 9'h07F);
    window4(2048, 2048, 2048, 2048, 8);
    check_result("cleared", 2048, 0, 9'h000);

    // 3: clamp and quantizer boundaries
    window4(2000, 4095, 100, 4095, 8);
    check_result("clamp", 4095, 9, 9'h1FF);
    window4(2175, 2100, 2175, 0, 8);
    check_result("b2175", 2175, 0, 9'h000);
    window4(2176, 2000, 2176, 2100, 8);
    check_result("b2176", 2176, 1, 9'h001);
    window4(3199, 3000, 2500, 3199, 8);
    check_result("b3199", 3199, 8, 9'h0FF);

    // 4: hold, transfer on load edge, then overwrite
    @(negedge clock);
    level_ready = 1'b0;
    window4(2300, 2300, 2300, 2300, 7);
    check_result("hs_a", 2300, 1, 9'h001);
    chk("hs_a_overrun", overrun, 0);
    window4(2600, 2600, 2600, 2600, 8);
    @(negedge clock);
    chk("hs_hold_valid", level_valid, 1);
    chk("hs_hold_peak", peak, 2300);
    chk("hs_hold_level", level, 1);
    level_ready = 1'b1;
    @(negedge clock);
    chk("hs_b_valid", level_valid, 1);
    chk("hs_b_peak", peak, 2600);
    chk("hs_b_level", level, 4);
    chk("hs_b_led", led, 9'h00F);
    chk("hs_b_overrun", overrun, 0);
    level_ready = 1'b0;
    window4(2048, 2048, 2048, 2048, 8);
    check_result("hs_c", 2048, 0, 9'h000);
    chk("hs_c_overrun", overrun, 1);

    // 5: partial window discarded by enable drop
    level_ready = 1'b1;
    @(negedge clock);
    drive(3000, 7);
    drive(3000, 10);
    @(negedge clock);
    enable = 1'b0;
    repeat (5) begin
      @(negedge clock);
      chk("idle_no_tick", sample_tick, 0);
    end
    chk("idle_valid", level_valid, 0);
    enable = 1'b1;
    window4(2200, 2200, 2200, 2200, 10);
    check_result("reenable", 2200, 1, 9'h001);

    // 6: reset while valid and overrun are high
    level_ready = 1'b0;
    @(negedge clock);
    chk("pre_rst_valid", level_valid, 1);
    chk("pre_rst_overrun", overrun, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_valid", level_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_peak", peak, 0);
    chk("mid_rst_led", led, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_tick", sample_tick, 0);
    reset = 1'b0;
    wait_tick(n);
    chk("post_rst_first_tick", n, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
